vc_pop_arbiter: RTL and testbench



---
 rtl/vc_arb_pkg.sv | 14 +
 rtl/vc_grant_counter.sv | 27 ++
 rtl/vc_pop_arbiter.sv | 101 ++++++++++
 tb/tb_vc_pop_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vc_arb_pkg.sv
// Shared definitions for the VC pop arbiter: FSM state encoding and default widths.
package vc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VC0   = 2'd1,
        ST_VC1   = 2'd2,
        ST_PAUSE = 2'd3
    } arb_state_t;

    localparam int unsigned DEF_DATA_WIDTH = 6;
    localparam int unsigned DEF_DEST_BIT   = 4;

endpackage

// File: rtl/vc_grant_counter.sv
// Saturating count of consecutive VC0 grants; sat tells the arbiter VC1 is owed a turn.
module vc_grant_counter #(
    parameter int unsigned WEIGHT = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [CNT_W-1:0] W_MAX = CNT_W'(WEIGHT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != W_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign sat = (r_cnt == W_MAX);

endmodule

// File: rtl/vc_pop_arbiter.sv
// Pops VC0/VC1 FIFOs into destination FIFOs D0/D1, stalling on almost-full.
// Define VC_WRR_EN for weighted round-robin; otherwise VC0 has strict priority.
module vc_pop_arbiter
    import vc_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEST_BIT   = DEF_DEST_BIT,
    parameter int unsigned WEIGHT_VC0 = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty_vc0,
    input  logic                  empty_vc1,
    input  logic [DATA_WIDTH-1:0] data_vc0,
    input  logic [DATA_WIDTH-1:0] data_vc1,
    input  logic                  almost_full_d0,
    input  logic                  almost_full_d1,
    output logic                  pop_vc0,
    output logic                  pop_vc1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  push_d0,
    output logic                  push_d1,
    output logic [1:0]            arb_state
);

    arb_state_t            r_state, w_next_state;
    logic                  w_pause, w_grant0, w_grant1, w_vc1_owed;
    logic                  r_valid, r_src;
    logic                  r_push_d0, r_push_d1;
    logic [DATA_WIDTH-1:0] r_data_out, w_word;

    // Destination is only known after the read, so either almost-full stalls.
    assign w_pause = almost_full_d0 | almost_full_d1;

`ifdef VC_WRR_EN
    vc_grant_counter #(
        .WEIGHT (WEIGHT_VC0),
        .CNT_W  (CNT_W)
    ) u_grant_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_grant0),
        .clr   (w_grant1),
        .sat   (w_vc1_owed)
    );
`else
    logic w_unused_wrr_cfg;
    assign w_unused_wrr_cfg = (WEIGHT_VC0 > 0) ^ (CNT_W > 0);
    assign w_vc1_owed       = 1'b0;
`endif

    always_comb begin
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        w_next_state = ST_IDLE;
        if (!reset) begin
            w_next_state = ST_IDLE;
        end else if (w_pause) begin
            w_next_state = ST_PAUSE;
        end else if (empty_vc0 && empty_vc1) begin
            w_next_state = ST_IDLE;
        end else if (empty_vc0 || (!empty_vc1 && w_vc1_owed)) begin
            w_grant1     = 1'b1;
            w_next_state = ST_VC1;
        end else begin
            w_grant0     = 1'b1;
            w_next_state = ST_VC0;
        end
    end

    assign w_word = r_src ? data_vc1 : data_vc0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_valid    <= 1'b0;
            r_src      <= 1'b0;
            r_push_d0  <= 1'b0;
            r_push_d1  <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_state    <= w_next_state;
            r_valid    <= w_grant0 | w_grant1;
            r_src      <= w_grant1;
            r_push_d0  <= r_valid & ~w_word[DEST_BIT];
            r_push_d1  <= r_valid &  w_word[DEST_BIT];
            if (r_valid) begin
                r_data_out <= w_word;
            end
        end
    end

    assign pop_vc0   = w_grant0;
    assign pop_vc1   = w_grant1;
    assign push_d0   = r_push_d0;
    assign push_d1   = r_push_d1;
    assign data_out  = r_data_out;
    assign arb_state = r_state;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed plus randomized bench for vc_pop_arbiter against a queue-based reference model.
module tb_vc_pop_arbiter;

    localparam int DW     = 6;
    localparam int DB     = 4;
    localparam int WEIGHT = 4;
    localparam int NSCHED = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          empty_vc0, empty_vc1;
    logic [DW-1:0] data_vc0, data_vc1;
    logic          almost_full_d0, almost_full_d1;
    logic          pop_vc0, pop_vc1;
    logic [DW-1:0] data_out;
    logic          push_d0, push_d1;
    logic [1:0]    arb_state;

    vc_pop_arbiter #(
        .DATA_WIDTH (DW),
        .DEST_BIT   (DB),
        .WEIGHT_VC0 (WEIGHT),
        .CNT_W      (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .empty_vc0      (empty_vc0),
        .empty_vc1      (empty_vc1),
        .data_vc0       (data_vc0),
        .data_vc1       (data_vc1),
        .almost_full_d0 (almost_full_d0),
        .almost_full_d1 (almost_full_d1),
        .pop_vc0        (pop_vc0),
        .pop_vc1        (pop_vc1),
        .data_out       (data_out),
        .push_d0        (push_d0),
        .push_d1        (push_d1),
        .arb_state      (arb_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: FIFO contents, expected pushes per cycle, previous decision.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    bit            sched_v[NSCHED];
    logic [DW-1:0] sched_w[NSCHED];
    int            cyc          = 0;
    int            prev_g       = 0;
    logic [DW-1:0] prev_w       = '0;
    int            prev_state   = 0;
    bit            prev_rst_low = 1'b1;
    int            vc0_run      = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit af0, input bit af1);
        int            g;
        int            st;
        logic [DW-1:0] w;
        @(negedge clk);
        data_vc0 = DW'($urandom);
        data_vc1 = DW'($urandom);
        if (prev_g == 1) data_vc0 = prev_w;
        else if (prev_g == 2) data_vc1 = prev_w;
        reset          = rst;
        almost_full_d0 = af0;
        almost_full_d1 = af1;
        empty_vc0      = (q0.size() == 0);
        empty_vc1      = (q1.size() == 0);
        #1;
        g  = 0;
        st = 0;
        if (!rst) begin
            st = 0;
        end else if (af0 || af1) begin
            st = 3;
        end else if (q0.size() == 0 && q1.size() == 0) begin
            st = 0;
        end else if (q0.size() == 0) begin
            g = 2;
        end else if (q1.size() == 0) begin
            g = 1;
        end else begin
`ifdef VC_WRR_EN
            g = (vc0_run >= WEIGHT) ? 2 : 1;
`else
            g = 1;
`endif
        end
        if (g != 0) st = g;

        chk("pop_vc0", 8'(pop_vc0), 8'(g == 1));
        chk("pop_vc1", 8'(pop_vc1), 8'(g == 2));
        chk("arb_state", 8'(arb_state), 8'(prev_state));
        chk("push_d0", 8'(push_d0), 8'(sched_v[cyc] && !sched_w[cyc][DB]));
        chk("push_d1", 8'(push_d1), 8'(sched_v[cyc] && sched_w[cyc][DB]));
        if (sched_v[cyc]) chk("data_out", 8'(data_out), 8'(sched_w[cyc]));
        else if (prev_rst_low) chk("data_out_rst", 8'(data_out), 8'h00);

        w = '0;
        if (g == 1) w = q0.pop_front();
        else if (g == 2) w = q1.pop_front();
        if (g != 0) begin
            sched_v[cyc+2] = 1'b1;
            sched_w[cyc+2] = w;
        end
        if (!rst) sched_v[cyc+1] = 1'b0;

        if (!rst || g == 2) vc0_run = 0;
        else if (g == 1 && vc0_run < WEIGHT) vc0_run++;

        prev_g       = g;
        prev_w       = w;
        prev_state   = st;
        prev_rst_low = !rst;
        cyc++;
    endtask

    initial begin
        reset          = 1'b0;
        almost_full_d0 = 1'b0;
        almost_full_d1 = 1'b0;
        empty_vc0      = 1'b1;
        empty_vc1      = 1'b1;
        data_vc0       = '0;
        data_vc1       = '0;

        // Reset held with both FIFOs non-empty.
        q0.push_back(6'h01); q0.push_back(6'h12);
        q1.push_back(6'h23); q1.push_back(6'h34);
        repeat (3) step(0, 0, 0);
        q0.delete(); q1.delete();
        repeat (3) step(1, 0, 0);

        // VC0 alone, three D0-bound words.
        for (int i = 0; i < 3; i++) q0.push_back(DW'(i + 1));
        repeat (6) step(1, 0, 0);

        // Both VCs loaded: priority pattern.
        for (int i = 0; i < 10; i++) begin
            q0.push_back(DW'($urandom));
            q1.push_back(DW'($urandom));
        end
        repeat (24) step(1, 0, 0);

        // almost_full_d1 pulse mid-stream.
        for (int i = 0; i < 8; i++) begin
            q0.push_back(DW'($urandom));
            q1.push_back(DW'($urandom));
        end
        repeat (3) step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        repeat (16) step(1, 0, 0);

        // VC1 stream with alternating destination bit.
        for (int i = 0; i < 8; i++) q1.push_back((i % 2 == 1) ? DW'(6'h10 | i) : DW'(i));
        repeat (12) step(1, 0, 0);

        // Reset falls the cycle after a pop.
        q0.push_back(6'h2A);
        q1.push_back(6'h15);
        step(1, 0, 0);
        step(0, 0, 0);
        repeat (4) step(1, 0, 0);

        // Randomized traffic with pauses and occasional resets.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 3) == 0 && q0.size() < 12) q0.push_back(DW'($urandom));
            if ($urandom_range(0, 3) == 0 && q1.size() < 12) q1.push_back(DW'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < 5; k++) q0.push_back(DW'($urandom));
                for (int k = 0; k < 5; k++) q1.push_back(DW'($urandom));
            end
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0));
        end
        repeat (4) step(1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
